// File: rtl/aes_inv_cipher_ctrl_pkg.sv
// aes_pkg: shared AES types, sizes and bytewise inverse-cipher primitives.
package aes_pkg;
    localparam int AES_BLOCK_W = 128;
    localparam int AES128_NR = 10;
    localparam int AES_KA_W = 4;
    typedef enum logic [2:0] {IDLE, ADDK, ROUND, FINAL, DONE} aes_inv_fsm_t;
    // Byte 0 sits in the most significant byte; byte index is row + 4*column.
    typedef logic [0:15][7:0] aes_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction

    // Undo the affine map, then take the GF(2^8) inverse as x^254.
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] s = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[r + 4 * c] = s[r + 4 * ((c - r + 4) % 4)];
        return o;
    endfunction

    function automatic aes_state_t inv_sub_bytes(input aes_state_t s);
        aes_state_t o;
        for (int i = 0; i < 16; i++) o[i] = inv_sbox(s[i]);
        return o;
    endfunction

    function automatic aes_state_t inv_mix_columns(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[4 * c + r] = gmul(8'h0e, s[4 * c + r]) ^ gmul(8'h0b, s[4 * c + (r + 1) % 4])
                             ^ gmul(8'h0d, s[4 * c + (r + 2) % 4]) ^ gmul(8'h09, s[4 * c + (r + 3) % 4]);
        return o;
    endfunction
endpackage

// File: rtl/aes_inv_cipher_ctrl_round.sv
// aes_inv_round: combinational inverse round; MixColumns skipped on the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] st,
    input  logic [AES_BLOCK_W-1:0] rk,
    input  logic                   final_rnd,
    output logic [AES_BLOCK_W-1:0] out
);
    aes_state_t keyed;
    assign keyed = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
    assign out = final_rnd ? keyed : inv_mix_columns(keyed);
endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl: iterative AES-128 decryption sequencer, one inverse round per cycle,
// round keys fetched 10 down to 0 from a 1-cycle-latency key store.
module aes_inv_cipher_ctrl
    import aes_pkg::*;
#(
    parameter int NR   = AES128_NR,
    parameter int KA_W = AES_KA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    output logic [KA_W-1:0]        rk_addr,
    input  logic [AES_BLOCK_W-1:0] rk_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy
);
    if (NR != AES128_NR) begin : g_nr_check
        $error("aes_inv_cipher_ctrl supports only NR=10");
    end

    localparam logic [KA_W-1:0] ADDR_NR  = KA_W'(NR);
    localparam logic [KA_W-1:0] ADDR_NR1 = KA_W'(NR - 1);
    localparam logic [KA_W-1:0] ADDR_NR2 = KA_W'(NR - 2);
    localparam logic [3:0]      RND_LAST = 4'(NR - 1);

    aes_inv_fsm_t           state_q, state_d;
    logic [AES_BLOCK_W-1:0] st_q, st_d, round_out;
    logic [3:0]             rnd_q, rnd_d;
    logic [KA_W-1:0]        rk_addr_q, rk_addr_d;

    aes_inv_round u_round (
        .st(st_q),
        .rk(rk_data),
        .final_rnd(state_q == FINAL),
        .out(round_out)
    );

    always_comb begin
        state_d = state_q;
        st_d = st_q;
        rnd_d = rnd_q;
        rk_addr_d = rk_addr_q;
        case (state_q)
            IDLE: if (in_valid) begin
                st_d = in_data;
                rk_addr_d = ADDR_NR1;
                state_d = ADDK;
            end
            ADDK: begin
                st_d = st_q ^ rk_data;
                rk_addr_d = ADDR_NR2;
                rnd_d = 4'd1;
                state_d = ROUND;
            end
            ROUND: begin
                st_d = round_out;
                rk_addr_d = (rk_addr_q == '0) ? '0 : rk_addr_q - KA_W'(1);
                rnd_d = rnd_q + 4'd1;
                state_d = (rnd_q == RND_LAST) ? FINAL : ROUND;
            end
            FINAL: begin
                st_d = round_out;
                rk_addr_d = ADDR_NR;
                state_d = DONE;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            st_q <= '0;
            rnd_q <= '0;
            rk_addr_q <= ADDR_NR;
        end else begin
            state_q <= state_d;
            st_q <= st_d;
            rnd_q <= rnd_d;
            rk_addr_q <= rk_addr_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy = (state_q != IDLE);
    assign rk_addr = rk_addr_q;
    // Only a finished block is ever visible on out_data.
    assign out_data = out_valid ? st_q : '0;
endmodule

// File: doc/aes_inv_cipher_ctrl.md
# aes_inv_cipher_ctrl

Iterative AES-128 decryption sequencer. It accepts one 128-bit ciphertext block over a valid/ready handshake and fetches round keys 10 down to 0 from the external key store. It applies one inverse round per cycle through a combinational inverse-round datapath built from the team's InvShiftRows, InvSubBytes and InvMixColumns blocks, then presents the plaintext over a valid/ready handshake. It sits between the block-input FIFO and the output formatter, next to the key-expansion RAM.

## Interface
- NR, 10: number of rounds. Only 10 (AES-128) is supported; other values are an elaboration error.
- KA_W, 4: round-key address width.
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ciphertext block offered.
- in_ready  out  1  block accepted when in_valid && in_ready.
- in_data  in  128  ciphertext; byte 0 in [127:120], column-major.
- rk_addr  out  KA_W  registered round-key index for the key store.
- rk_data  in  128  round key for the rk_addr value of the previous cycle (fixed 1-cycle read latency).
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  128  plaintext; same byte order as in_data.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ADDK, ROUND, FINAL, DONE.
- Registers: state register st[127:0], round counter rnd[3:0], rk_addr.
- IDLE:
  - in_ready=1 and rk_addr holds NR.
  - On accept: st<=in_data, rk_addr<=NR-1, go to ADDK.
- ADDK:
  - st<=st^rk_data (rk_data is key NR).
  - rk_addr<=NR-2, rnd<=1, go to ROUND.
- ROUND (rnd 1..NR-1):
  - st<=InvMixColumns(InvSubBytes(InvShiftRows(st))^rk_data).
  - rk_addr decrements, floored at 0.
  - rnd increments.
  - Go to FINAL when rnd==NR-1.
- FINAL:
  - st<=InvSubBytes(InvShiftRows(st))^rk_data (key 0).
  - rk_addr<=NR, go to DONE.
- DONE:
  - out_valid=1, out_data=st.
  - st, out_data and rk_addr stay stable while out_ready=0.
  - On out_ready: go to IDLE.
- Ignored inputs:
  - in_valid outside IDLE has no effect; in_ready=0 there.
  - out_ready outside DONE has no effect.
- in_ready=(state==IDLE) and out_valid=(state==DONE); both are combinational decodes of registered state.
- Bytewise operations only. No widths change, no arithmetic beyond the 4-bit counter and address decrement.

## Timing
- Accept at cycle T gives:
  - ADDK at T+1
  - ROUND at T+2..T+10, using keys 9..1
  - FINAL at T+11
  - out_valid first high at T+12
- Latency from accept to out_valid is 12 cycles.
- rk_addr sequence from T: 10 (at T), 9 (T+1), 8, …, 1, 0 (T+10), 0 (T+11), 10 (T+12).
- With out_ready held high, in_ready returns at T+13, giving a minimum issue interval of 13 cycles.
- Reset values: in_ready=1, out_valid=0, busy=0, out_data=0, rk_addr=NR, rnd=0, state=IDLE.
- rst in any state, including mid-round and DONE with out_ready low, aborts the block:
  - outputs take their reset values on the next cycle
  - no partial result is ever presented
- rst has priority over simultaneous in_valid or out_ready.

## Structure
- Shared package aes_pkg holds:
  - enum aes_inv_fsm_t {IDLE, ADDK, ROUND, FINAL, DONE}
  - AES_BLOCK_W=128, AES128_NR=10, AES_KA_W=4
  - a byte-array state typedef
- One sub-module, aes_inv_round:
  - purely combinational
  - inputs: st, rk, final_rnd
  - instantiates the existing inverse ShiftRows, SubBytes and MixColumns blocks
  - MixColumns is bypassed when final_rnd=1
- The controller holds all registers.

## Test plan
- Known answer (FIPS-197 C.1):
  - key store holds the expansion of 000102030405060708090a0b0c0d0e0f (key 10 = 13111d7fe3944a17f307a78b4d2b30c5)
  - in_data=69c4e0d86a7b0430d8cdb78070b4c55a
  - expect out_data=00112233445566778899aabbccddeeff at T+12
- rk_addr trace: check the exact sequence 10,9,…,1,0,0,10 against cycles T..T+12.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid, with in_valid=1 and a different in_data throughout. Expect:
  - out_data stable
  - in_ready=0
  - the second block is not accepted until the cycle after the out handshake
- Back-to-back: two C.1 blocks with in_valid and out_ready held high.
  - accepts occur at cycles T and T+13
  - both outputs are correct
- Reset mid-operation: assert rst at T+6 for 1 cycle. Expect:
  - T+7: in_ready=1, out_valid=0, rk_addr=10, busy=0
  - no out_valid within the following 15 cycles
  - a new block then completes correctly
- Reset in DONE with out_ready=0: out_valid drops the next cycle and out_data=0.
